// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory arbiter
//
// Purpose: size encodings, FSM state enum, grant-id enum and the alignment
// check shared by mem_arbiter and store_merge.
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RESP   = 2'b01,
        RMW_WR = 2'b10,
        ERR    = 2'b11
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    // Size 11 is illegal; halves need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_merge.sv
// rtl/store_merge.sv - byte/half lane merge for read-modify-write stores
//
// Purpose: replaces the addressed byte or halfword lane of old_word with the
// right-justified store data; a word size passes wdata straight through.
// Ports:
//   old_word  in  32  word read back from the RAM
//   wdata     in  32  store data, right-justified
//   size      in  2   access size encoding
//   offset    in  2   byte offset within the word
//   merged    out 32  word to write back
module store_merge
    import mem_arb_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter for a single-port word RAM
//
// Purpose: grants one of the fetch and load/store ports per access, drives the
// RAM pins, returns read data one cycle after the read edge, and runs byte and
// half stores as a read followed by a merged write.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   if_req_valid/ready, if_addr  fetch request (byte address, [1:0] ignored)
//   if_rvalid, if_rdata          fetch response pulse and word
//   d_req_valid/ready, d_we, d_size, d_addr, d_wdata   data request
//   d_rvalid, d_rdata            load response pulse and full aligned word
//   d_err                        misaligned/illegal request pulse
//   ram_r_wn, ram_address, ram_data_in, ram_data_out   RAM pins
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W+1:0] if_addr,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W+1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              ram_r_wn,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data_in,
    input  logic [31:0]       ram_data_out
);

    arb_state_t        state_q, state_d;
    gnt_t              last_gnt_q, last_gnt_d;
    gnt_t              gnt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merged;
    logic              d_mis;
    logic              if_addr_unused;

    assign if_addr_unused = ^if_addr[1:0];

    assign if_rdata = ram_data_out;
    assign d_rdata  = ram_data_out;
    assign d_mis    = is_misaligned(d_size, d_addr[1:0]);

    store_merge u_store_merge (
        .old_word (ram_data_out),
        .wdata    (wdata_q),
        .size     (size_q),
        .offset   (off_q),
        .merged   (merged)
    );

    always_comb begin
        if (if_req_valid && d_req_valid) begin
            gnt = (last_gnt_q == GNT_IF) ? GNT_D : GNT_IF;
        end else if (d_req_valid) begin
            gnt = GNT_D;
        end else begin
            gnt = GNT_IF;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        addr_d       = addr_q;
        off_d        = off_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        if_rvalid    = 1'b0;
        d_rvalid     = 1'b0;
        d_err        = 1'b0;
        ram_r_wn     = 1'b1;
        ram_data_in  = 32'h0;

        case (state_q)
            IDLE: begin
                if (if_req_valid || d_req_valid) begin
                    last_gnt_d = gnt;
                    if (gnt == GNT_IF) begin
                        if_req_ready = 1'b1;
                        addr_d       = if_addr[ADDR_W+1:2];
                        state_d      = RESP;
                    end else begin
                        d_req_ready = 1'b1;
                        if (d_mis) begin
                            // Accepted but never touches the RAM.
                            state_d = ERR;
                        end else begin
                            addr_d = d_addr[ADDR_W+1:2];
                            if (!d_we) begin
                                state_d = RESP;
                            end else if (d_size == SZ_WORD) begin
                                ram_r_wn    = 1'b0;
                                ram_data_in = d_wdata;
                            end else begin
                                // Read the old word now; merge and write next cycle.
                                off_d   = d_addr[1:0];
                                size_d  = d_size;
                                wdata_d = d_wdata;
                                state_d = RMW_WR;
                            end
                        end
                    end
                end
            end
            RESP: begin
                // last_gnt_q still names the port whose read is in flight.
                if_rvalid = (last_gnt_q == GNT_IF);
                d_rvalid  = (last_gnt_q == GNT_D);
                state_d   = IDLE;
            end
            RMW_WR: begin
                ram_r_wn    = 1'b0;
                ram_data_in = merged;
                state_d     = IDLE;
            end
            ERR: begin
                d_err   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset masks everything visible immediately, so an RMW write in
        // flight is dropped before its write edge.
        if (rst) begin
            if_req_ready = 1'b0;
            d_req_ready  = 1'b0;
            if_rvalid    = 1'b0;
            d_rvalid     = 1'b0;
            d_err        = 1'b0;
            ram_r_wn     = 1'b1;
        end
    end

    assign ram_address = addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= GNT_IF;
            addr_q     <= '0;
            off_q      <= 2'b00;
            size_q     <= SZ_BYTE;
            wdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 4096 x 32 word RAM between the instruction-fetch port and the load/store port of the RISC-V core. It arbitrates round-robin when both ports request and converts byte-addressed, sized data accesses into word RAM cycles. Sub-word stores run as read-modify-write. It sits between the core's memory stage and the RAM instance, and drives the RAM's `r_wn`, `address` and `data_in` pins.

## Interface
- `ADDR_W`, 12: RAM word-address width. The byte address width is `ADDR_W+2`.
- `clk`  in  1  clock; all RAM and arbiter activity on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_addr`  in  ADDR_W+2  fetch byte address; bits [1:0] are ignored.
- `if_rvalid`  out  1  fetch data valid, 1-cycle pulse.
- `if_rdata`  out  32  fetch word.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_we`  in  1  1 = store, 0 = load.
- `d_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `d_addr`  in  ADDR_W+2  data byte address.
- `d_wdata`  in  32  store data, right-justified.
- `d_rvalid`  out  1  load data valid, 1-cycle pulse.
- `d_rdata`  out  32  full aligned word, unshifted.
- `d_err`  out  1  misaligned or illegal request, 1-cycle pulse.
- `ram_r_wn`  out  1  1 = read, 0 = write.
- `ram_address`  out  ADDR_W  RAM word address.
- `ram_data_in`  out  32  RAM write data.
- `ram_data_out`  in  32  RAM read data; valid the cycle after a read edge.

## Operation
- FSM states: IDLE, RESP, RMW_WR, ERR.
- Ready outputs are high only in IDLE, and only for the granted port. Ready depends combinationally on valid.
- Grant rule:
  - If only one port is valid, that port is granted.
  - If both are valid, the port not granted last is granted.
  - The last-grant pointer resets to "fetch", so data wins the first tie.
- Alignment check (data port only):
  - Misaligned means half with `d_addr[0]`=1, word with `d_addr[1:0]`≠0, or `d_size`=11.
  - A misaligned request is accepted, performs no RAM write, and moves to ERR.
  - ERR pulses `d_err` for one cycle, then returns to IDLE.
- In IDLE, `ram_address` and `ram_r_wn` are driven combinationally from the granted request, so the RAM captures the access on the accepting edge.
- Fetch, or data load: `ram_r_wn`=1, then go to RESP. RESP pulses the matching `*_rvalid` with `*_rdata` = `ram_data_out`, then returns to IDLE.
- Word store: `ram_r_wn`=0, `ram_data_in` = `d_wdata`. Completes on the accept edge, stays in IDLE, no response pulse.
- Byte or half store:
  - On accept, a read is issued and the byte offset, size and wdata are registered. The next state is RMW_WR.
  - RMW_WR drives `ram_r_wn`=0 and `ram_data_in` = merge(`ram_data_out`, registered wdata). It then returns to IDLE, with no response pulse.
  - Merge, byte: `wdata[7:0]` replaces lane `addr[1:0]`.
  - Merge, half: `wdata[15:0]` replaces bits [16*addr[1] +: 16].
- When there is no access, `ram_r_wn`=1 and `ram_address` holds its last value, so no write ever happens spuriously.

## Timing
- Reset values: state IDLE, pointer = fetch.
- While `rst` is high:
  - Both readies are forced to 0.
  - `ram_r_wn` is forced to 1.
  - All `*_rvalid` and `d_err` outputs are 0.
- Reset asserted in RMW_WR aborts the write and the RAM word is left unchanged. Reset asserted in RESP drops the pulse.
- Latencies:
  - Read: accept at edge N, rvalid high in cycle N+1. Throughput is one read per 2 cycles.
  - Word store: 1 cycle.
  - Sub-word store: 2 cycles, with the write at edge N+1.
  - Error: `d_err` high in cycle N+1.
- The port that loses arbitration must hold its request stable. Nothing is queued inside the arbiter.
- Read-after-write to the same word always returns the new data, because a store fully completes before the next accept.

## Structure
- Package `mem_arb_pkg` holds:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the FSM state enum;
  - the grant-id enum (`GNT_IF`, `GNT_D`).
- One combinational sub-module, `store_merge`, with inputs old word, wdata, size and offset, and output the merged word.
- The RAM stays a separate instance. `mem_arbiter` does not contain the array.

## Test plan
- Word store 0xDEADBEEF at byte 0x010, then load 0x010: `ram_r_wn`=0 for 1 cycle, then `d_rvalid` one cycle after accept with `d_rdata`=0xDEADBEEF.
- Byte store 0xAA at byte 0x013 over word 0x11223344: RAM read, then write 0xAA223344; the reload returns 0xAA223344.
- Half store 0x5566 at byte 0x012 over 0x11223344: the word becomes 0x55663344. A half store to 0x011 gives a `d_err` pulse and the word is unchanged.
- Both ports valid continuously, starting from reset: grant order D, IF, D, IF. Each read returns the correct word, and no port waits more than one request.
- Reset asserted in RMW_WR of a byte store: no write edge occurs. After reset, the original word is intact and both readies are 0 during reset.
- `d_size`=11 load at an aligned address: accepted, then `d_err` pulse, no `d_rvalid`, and `ram_r_wn` stays 1.
